// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
// Imported by md_unit, its decoder and the hazard unit.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

  function automatic logic md_is_mul(logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic md_is_div(logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_if.sv
// E-stage to md_unit bundle: operation request in, busy/HI/LO out.
// master = pipeline side, slave = md_unit.
interface md_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_val, rt_val, flush,
    input  busy, hi, lo
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, flush,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath; result is {hi, lo}.
// Division works on magnitudes so 0x80000000 / -1 needs no special case.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  md_op_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] rt_val_i,
  output logic [63:0] res_o,
  output logic        div_by_zero_o
);

  logic        sgn;
  logic        is_mul;
  logic        is_div;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        q_neg;
  logic        r_neg;

  assign sgn    = (md_op_i == MD_MULT) || (md_op_i == MD_DIV);
  assign is_mul = md_is_mul(md_op_i);
  assign is_div = md_is_div(md_op_i);

  assign a_ext = {{32{sgn & rs_val_i[31]}}, rs_val_i};
  assign b_ext = {{32{sgn & rt_val_i[31]}}, rt_val_i};
  assign prod  = a_ext * b_ext;

  assign a_mag = (sgn && rs_val_i[31]) ? (~rs_val_i + 32'd1) : rs_val_i;
  assign b_mag = (sgn && rt_val_i[31]) ? (~rt_val_i + 32'd1) : rt_val_i;

  assign div_by_zero_o = is_div && (rt_val_i == 32'd0);
  assign b_safe = (rt_val_i == 32'd0) ? 32'd1 : b_mag;

  assign q_mag = a_mag / b_safe;
  assign r_mag = a_mag % b_safe;
  assign q_neg = sgn & (rs_val_i[31] ^ rt_val_i[31]);
  assign r_neg = sgn & rs_val_i[31];
  assign quo   = q_neg ? (~q_mag + 32'd1) : q_mag;
  assign rem   = r_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    res_o = '0;
    unique case (1'b1)
      is_mul:  res_o = prod;
      is_div:  res_o = {rem, quo};
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle MULT/DIV sequencer with HI/LO registers for the E stage.
// Optional MD_FLUSH_EN lets flush cancel an in-flight or starting op.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input logic clk,
  input logic reset,
  md_if.slave bus
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                                 MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CLW  = $clog2(MAXC + 1);
  localparam int unsigned CW   = (CLW > 4) ? CLW : 4;

  md_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] p_hi_q;
  logic [31:0] p_lo_q;
  logic        p_dz_q;

  logic [63:0]   res_d;
  logic          dz_d;
  logic          flush_d;
  logic          op_arith_d;
  logic          op_mthi_d;
  logic          op_mtlo_d;
  logic [CW-1:0] cnt_load_d;

  md_arith u_arith (
    .md_op_i       (bus.md_op),
    .rs_val_i      (bus.rs_val),
    .rt_val_i      (bus.rt_val),
    .res_o         (res_d),
    .div_by_zero_o (dz_d)
  );

`ifdef MD_FLUSH_EN
  assign flush_d = bus.flush;
`else
  logic unused_flush;
  assign unused_flush = bus.flush;
  assign flush_d      = 1'b0;
`endif

  assign op_arith_d = md_is_mul(bus.md_op) | md_is_div(bus.md_op);
  assign op_mthi_d  = (bus.md_op == MD_MTHI);
  assign op_mtlo_d  = (bus.md_op == MD_MTLO);
  assign cnt_load_d = md_is_mul(bus.md_op) ?
                      CW'(MULT_CYCLES) : CW'(DIV_CYCLES);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      p_dz_q  <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (bus.start && !flush_d) begin
            unique case (1'b1)
              op_arith_d: begin
                p_hi_q  <= res_d[63:32];
                p_lo_q  <= res_d[31:0];
                p_dz_q  <= dz_d;
                cnt_q   <= cnt_load_d;
                state_q <= MD_RUN;
              end
              op_mthi_d: hi_q <= bus.rs_val;
              op_mtlo_d: lo_q <= bus.rs_val;
              default: ;
            endcase
          end
        end
        MD_RUN: begin
          if (flush_d) begin
            cnt_q   <= '0;
            state_q <= MD_IDLE;
          end else if (cnt_q == CW'(1)) begin
            // divide-by-zero still burns its cycles but leaves HI/LO alone
            if (!p_dz_q) begin
              hi_q <= p_hi_q;
              lo_q <= p_lo_q;
            end
            cnt_q   <= '0;
            state_q <= MD_IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q == MD_RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed + randomized bench for md_unit against a 64-bit arithmetic model.
// Flush expectations follow whether MD_FLUSH_EN is defined.
module tb_md_unit;
  import md_pkg::*;

`ifdef MD_FLUSH_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  md_if bus();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural result of one op: new HI/LO and busy duration.
  task automatic model(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] nh,
                       output logic [31:0] nl, output int cyc);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, uq, ur, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    nh = m_hi;
    nl = m_lo;
    cyc = 0;
    case (op)
      3'd0: begin p = sa * sb; nh = p[63:32]; nl = p[31:0]; cyc = 5; end
      3'd1: begin up = ua * ub; nh = up[63:32]; nl = up[31:0]; cyc = 5; end
      3'd2: begin
        cyc = 10;
        if (b != 0) begin
          q = sa / sb; r = sa % sb; nl = q[31:0]; nh = r[31:0];
        end
      end
      3'd3: begin
        cyc = 10;
        if (b != 0) begin
          uq = ua / ub; ur = ua % ub; nl = uq[31:0]; nh = ur[31:0];
        end
      end
      3'd4: nh = a;
      3'd5: nl = a;
      default: ;
    endcase
  endtask

  // inj: 0 none, 1 start while busy, 2 flush in RUN at index at,
  // 3 flush together with the start.
  task automatic run(input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int inj, input int at,
                     input string tag);
    logic [31:0] nh, nl, oh, ol;
    int cyc, n;
    bit fl;
    model(op, a, b, nh, nl, cyc);
    oh = m_hi;
    ol = m_lo;
    fl = FL && (inj == 2 || inj == 3);
    if (fl && inj == 3) cyc = 0;
    if (fl && inj == 2) cyc = at + 1;
    if (fl) begin nh = oh; nl = ol; end
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = a;
    bus.rt_val = b;
    bus.flush  = (inj == 3);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.md_op  = 3'($urandom_range(0, 7));
    bus.rs_val = $urandom;
    bus.rt_val = $urandom;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      chk({tag, "_hold_hi"}, bus.hi, oh);
      chk({tag, "_hold_lo"}, bus.lo, ol);
      bus.start = (inj == 1 && n == at);
      bus.md_op = MD_MTLO;
      bus.flush = (inj == 2 && n == at);
      n++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk({tag, "_cycles"}, 32'(n), 32'(cyc));
    chk({tag, "_hi"}, bus.hi, nh);
    chk({tag, "_lo"}, bus.lo, nl);
    m_hi = nh;
    m_lo = nl;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] c [6];
    c = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};
    if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    logic [2:0] op;
    logic [31:0] a, b, th, tl;
    int cyc, inj, at;

    bus.start  = 1'b0;
    bus.md_op  = 3'd0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    bus.flush  = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    reset = 1'b1;

    run(MD_MTHI, 32'hA5A5A5A5, 32'd0, 0, 0, "mthi_a");
    run(MD_MTLO, 32'h5A5A5A5A, 32'd0, 0, 0, "mtlo_a");

    // reset while DIV is mid-flight (cnt == 6)
    bus.start  = 1'b1;
    bus.md_op  = MD_DIV;
    bus.rs_val = 32'd100;
    bus.rt_val = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("rstrun_busy", {31'd0, bus.busy}, 32'd0);
    chk("rstrun_hi", bus.hi, 32'd0);
    chk("rstrun_lo", bus.lo, 32'd0);
    m_hi = '0;
    m_lo = '0;
    repeat (12) @(negedge clk);
    chk("rstrun_discard_lo", bus.lo, 32'd0);
    run(MD_DIVU, 32'd7, 32'd2, 0, 0, "divu_7_2");
    chk("divu_7_2_const_hi", bus.hi, 32'd1);
    chk("divu_7_2_const_lo", bus.lo, 32'd3);

    run(MD_MULT, 32'hFFFFFFFF, 32'h2, 0, 0, "mult_neg");
    chk("mult_neg_const_hi", bus.hi, 32'hFFFFFFFF);
    run(MD_MULTU, 32'hFFFFFFFF, 32'h2, 0, 0, "multu");
    chk("multu_const_hi", bus.hi, 32'h1);
    run(MD_DIV, 32'hFFFFFFF9, 32'h2, 0, 0, "div_neg7");
    chk("div_neg7_const_lo", bus.lo, 32'hFFFFFFFD);
    run(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0, "div_ovf");
    chk("div_ovf_const_lo", bus.lo, 32'h80000000);
    chk("div_ovf_const_hi", bus.hi, 32'h0);
    run(MD_MTHI, 32'h12345678, 32'd0, 0, 0, "mthi");
    run(MD_DIVU, 32'd5, 32'd0, 0, 0, "divu_dz");
    chk("divu_dz_const_hi", bus.hi, 32'h12345678);
    run(MD_DIV, 32'd40, 32'd6, 0, 0, "b2b_div");
    run(MD_MULTU, 32'd3, 32'd4, 0, 0, "b2b_multu");
    chk("b2b_const_lo", bus.lo, 32'd12);
    run(MD_MULT, 32'd9, 32'd9, 1, 2, "start_busy");
    run(MD_MULT, 32'd11, 32'd13, 2, 2, "flush_run3");
    run(MD_MULT, 32'd17, 32'd19, 2, 4, "flush_commit");
    run(MD_MTHI, 32'hCAFEF00D, 32'd0, 3, 0, "flush_mthi");
    run(MD_DIV, 32'd77, 32'd5, 3, 0, "flush_start_div");
    run(3'd6, 32'h11111111, 32'd3, 0, 0, "rsv6");
    run(3'd7, 32'h22222222, 32'd3, 0, 0, "rsv7");

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = pick();
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      model(op, a, b, th, tl, cyc);
      inj = $urandom_range(0, 3);
      at = 0;
      if (cyc == 0 && inj != 3) inj = 0;
      if (cyc > 0 && inj != 3) at = $urandom_range(0, cyc - 1);
      run(op, a, b, inj, at, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit with HI/LO registers for the five-stage MIPS pipeline, instantiated in the E stage. It sequences MULT/MULTU/DIV/DIVU over a fixed cycle count, handles MTHI/MTLO writes, and drives HI/LO for MFHI/MFLO. Its `busy` output feeds the hazard unit, which must stall any multiply/divide-class instruction in D while `busy | start` is high.

## Interface
- MULT_CYCLES, 5, cycles `busy` stays high for MULT/MULTU (≥1)
- DIV_CYCLES, 10, cycles `busy` stays high for DIV/DIVU (≥1)
- clk  input  1  pipeline clock; all state changes on rising edge
- reset  input  1  synchronous, active-low reset
- start  input  1  E-stage instruction is an md op; sampled every cycle
- md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 reserved (no-op)
- rs_val  input  32  forwarded rs operand
- rt_val  input  32  forwarded rt operand
- flush  input  1  abort in-flight op (active only with MD_FLUSH_EN)
- busy  output  1  operation in progress
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- States: IDLE, RUN. Down-counter `cnt`, 4 bits minimum, sized to max(MULT_CYCLES, DIV_CYCLES).
- IDLE + start + MULT/MULTU/DIV/DIVU: latch result into pending regs (`p_hi`, `p_lo`), load `cnt` with the op's cycle count, go to RUN.
- IDLE + start + MTHI/MTLO: write rs_val to hi/lo at this edge; stay in IDLE; `busy` stays 0.
- start while RUN: ignored. The hazard unit guarantees this cannot occur.
- Reserved md_op: no effect.
- RUN: decrement `cnt` each cycle. When `cnt == 1`: commit `p_hi`/`p_lo` to hi/lo and go to IDLE.
- MULT: signed 32×32 → 64; hi = [63:32], lo = [31:0]. MULTU: unsigned.
- DIV: lo = quotient truncated toward zero; hi = remainder, with the dividend's sign.
- DIV overflow (0x80000000 / 0xFFFFFFFF): lo = 0x80000000, hi = 0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (rt_val == 0): op still runs the full DIV_CYCLES with `busy` high, but the commit leaves hi/lo unchanged.
- `busy = (state == RUN)`. It is a registered output with no combinational path from start.

## Timing
- Reset (reset == 0 at an edge): state IDLE, cnt 0, busy 0, hi 0, lo 0, p_hi/p_lo 0. Reset overrides start and flush. Reset during RUN discards the op.
- start MULT sampled at edge t: busy = 1 for cycles t+1 … t+MULT_CYCLES. New hi/lo are visible from cycle t+MULT_CYCLES+1, the same cycle busy returns to 0.
- A new start is accepted in the cycle busy falls, so back-to-back ops are possible.
- MTHI/MTLO: value is visible on hi/lo the cycle after start.
- MFHI/MFLO read the hi/lo outputs combinationally. A read in the first non-busy cycle sees the committed result.
- flush (with macro) sampled high in RUN: go to IDLE at that edge with no commit; busy = 0 next cycle; hi/lo keep their pre-op values.
- flush and start in the same IDLE cycle: start dropped, including MTHI/MTLO.
- flush in the same cycle as the commit edge (`cnt == 1`): flush wins, no commit.

## Configuration
- MD_FLUSH_EN defined: flush behaves as described in Timing. This supports exception/eret cancellation of an md op that entered E in the shadow of an exception.
- MD_FLUSH_EN undefined: the flush port still exists but is ignored. Started ops always complete and commit.

## Structure
- Shared package `md_pkg`:
  - md_op encodings (MD_MULT … MD_MTLO)
  - state encodings (MD_IDLE, MD_RUN)
  - default cycle constants
- The decoder and the hazard unit import the same encodings from it.
- One combinational sub-module, `md_arith`: inputs md_op, rs_val, rt_val; outputs 64-bit result and a div_by_zero flag. The FSM, counter, and HI/LO registers stay in `md_unit`.

## Test plan
- Reset low mid-DIV (cnt = 6) → next cycle busy 0, hi 0, lo 0; a later start DIVU 7/2 → hi 1, lo 3.
- MULT 0xFFFFFFFF × 0x00000002 → busy exactly 5 cycles; then hi 0xFFFFFFFF, lo 0xFFFFFFFE.
- MULTU with the same operands → hi 0x00000001, lo 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) / 2 → busy 10 cycles; then lo 0xFFFFFFFD, hi 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → lo 0x80000000, hi 0.
- MTHI 0x12345678, then DIVU 5/0 → busy 10 cycles; hi stays 0x12345678, lo unchanged.
- Back-to-back: MULTU 3×4 accepted on the busy-fall cycle after a prior DIV → lo 12.
- Start asserted while busy → ignored.
- MD_FLUSH_EN: flush at RUN cycle 3 of MULT → busy 0 next cycle, hi/lo unchanged.
- MD_FLUSH_EN: flush on the commit edge → no commit.
- MD_FLUSH_EN undefined: the same flush → result commits normally.
